// File: rtl/mcu_raster_reorder_pkg.sv
// Shared types and geometry helpers for the MCU-to-raster reorder buffer.
package mcu_raster_reorder_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

  function automatic int stripe_words(input int image_w);
    return image_w * 8;
  endfunction

  function automatic int blocks_per_stripe(input int image_w);
    return image_w / 8;
  endfunction

  function automatic int stripes_per_frame(input int image_h);
    return image_h / 8;
  endfunction

  function automatic int frame_pixels(input int image_w, input int image_h);
    return image_w * image_h;
  endfunction

  // Address/counter width that never collapses to zero bits.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/reorder_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module reorder_dp_ram #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mcu_raster_reorder.sv
// MCU-order to raster-order reorder with a two-stripe ping-pong buffer.
// Optional output backpressure: define MCU_RASTER_REORDER_OREADY_EN.
module mcu_raster_reorder
  import mcu_raster_reorder_pkg::*;
#(
  parameter int IMAGE_W    = 320,
  parameter int IMAGE_H    = 240,
  parameter int PIXEL_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ivalid,
  input  logic [PIXEL_BITS-1:0] ipixel,
`ifdef MCU_RASTER_REORDER_OREADY_EN
  input  logic                  oready,
`endif
  output logic                  ovalid,
  output logic [PIXEL_BITS-1:0] opixel,
  output logic [31:0]           pixel_id,
  output logic                  frame_done,
  output logic                  overflow,
  output rd_state_e             dbg_state
);

  localparam int STRIPE_WORDS      = stripe_words(IMAGE_W);
  localparam int BLOCKS_PER_STRIPE = blocks_per_stripe(IMAGE_W);
  localparam int FRAME_PIXELS      = frame_pixels(IMAGE_W, IMAGE_H);
  localparam int ADDR_W            = width_of(2 * STRIPE_WORDS);
  localparam int BLK_W             = width_of(BLOCKS_PER_STRIPE);
  localparam int OFF_W             = width_of(STRIPE_WORDS);
  localparam logic [BLK_W-1:0] B_LAST   = BLK_W'(BLOCKS_PER_STRIPE - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(STRIPE_WORDS - 1);
  localparam logic [31:0]      ID_LAST  = 32'(FRAME_PIXELS - 1);

  // Write side
  logic [2:0]       c_q, c_d, r_q, r_d;
  logic [BLK_W-1:0] b_q, b_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             wr_en, wr_last;
  logic [ADDR_W-1:0] wr_addr;

  // Read side
  rd_state_e        state_q, state_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic             rd_bank_q, rd_bank_d;
  logic             rd_en, rd_done, advance;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIXEL_BITS-1:0] rd_data;

  // Output stage
  logic        ovalid_q, ovalid_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] pixel_id_q, pixel_id_d;
  logic [31:0] cnt_q, cnt_d;

  // Handshake: a word transfers on a cycle with ovalid=1 and oready=1; while
  // ovalid=1 and oready=0 the output word and its id are held unchanged.
`ifdef MCU_RASTER_REORDER_OREADY_EN
  assign advance = !ovalid_q || oready;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    c_d        = c_q;
    r_d        = r_q;
    b_d        = b_q;
    wr_bank_d  = wr_bank_q;
    wr_last    = ivalid && (c_q == 3'd7) && (r_q == 3'd7) && (b_q == B_LAST);
    wr_en      = ivalid && !full_q[wr_bank_q];
    overflow_d = overflow_q | (ivalid && full_q[wr_bank_q]);
    wr_addr    = ADDR_W'(32'(wr_bank_q) * STRIPE_WORDS + 32'(r_q) * IMAGE_W
                         + 32'(b_q) * 8 + 32'(c_q));
    // Dropped pixels still advance the counters so stripe geometry stays aligned.
    if (ivalid) begin
      c_d = c_q + 3'd1;
      if (c_q == 3'd7) begin
        r_d = r_q + 3'd1;
        if (r_q == 3'd7) begin
          if (b_q == B_LAST) begin
            b_d       = '0;
            wr_bank_d = ~wr_bank_q;
          end else begin
            b_d = b_q + BLK_W'(1);
          end
        end
      end
    end
  end

  // Read FSM: IDLE issues offset 0 itself so the first word lands one cycle later.
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    rd_done   = 1'b0;
    rd_addr   = ADDR_W'(32'(rd_bank_q) * STRIPE_WORDS + 32'(offset_q));
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q] && advance) begin
          rd_en    = 1'b1;
          offset_d = OFF_W'(1);
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (advance) begin
          rd_en = 1'b1;
          if (offset_q == OFF_LAST) begin
            rd_done   = 1'b1;
            rd_bank_d = ~rd_bank_q;
            offset_d  = '0;
            state_d   = ST_IDLE;
          end else begin
            offset_d = offset_q + OFF_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set wins over clear when both sides touch the same bank in one cycle.
  always_comb begin
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  always_comb begin
    ovalid_d     = ovalid_q;
    frame_done_d = frame_done_q;
    pixel_id_d   = pixel_id_q;
    cnt_d        = cnt_q;
    if (advance) begin
      ovalid_d     = rd_en;
      frame_done_d = 1'b0;
      if (rd_en) begin
        pixel_id_d   = cnt_q;
        frame_done_d = (cnt_q == ID_LAST);
        cnt_d        = (cnt_q == ID_LAST) ? 32'd0 : cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q          <= '0;
      r_q          <= '0;
      b_q          <= '0;
      wr_bank_q    <= 1'b0;
      full_q       <= '0;
      overflow_q   <= 1'b0;
      state_q      <= ST_IDLE;
      offset_q     <= '0;
      rd_bank_q    <= 1'b0;
      ovalid_q     <= 1'b0;
      frame_done_q <= 1'b0;
      pixel_id_q   <= '0;
      cnt_q        <= '0;
    end else begin
      c_q          <= c_d;
      r_q          <= r_d;
      b_q          <= b_d;
      wr_bank_q    <= wr_bank_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      offset_q     <= offset_d;
      rd_bank_q    <= rd_bank_d;
      ovalid_q     <= ovalid_d;
      frame_done_q <= frame_done_d;
      pixel_id_q   <= pixel_id_d;
      cnt_q        <= cnt_d;
    end
  end

  // The RAM output register only reloads on an issued read, so it holds a
  // stalled word and acts as the single skid entry.
  reorder_dp_ram #(
    .DEPTH (2 * STRIPE_WORDS),
    .WIDTH (PIXEL_BITS),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(ipixel),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign ovalid     = ovalid_q;
  assign opixel     = ovalid_q ? rd_data : '0;
  assign pixel_id   = pixel_id_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mcu_raster_reorder.sv
// Bench for mcu_raster_reorder on a 16x16 image; raster-order model plus directed vectors.
module tb_mcu_raster_reorder;
  import mcu_raster_reorder_pkg::*;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int FP = W * H;
  localparam int SW = W * 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ivalid = 1'b0;
  logic [7:0]  ipixel = '0;
`ifdef MCU_RASTER_REORDER_OREADY_EN
  logic        oready = 1'b1;
`endif
  logic        ovalid;
  logic [7:0]  opixel;
  logic [31:0] pixel_id;
  logic        frame_done;
  logic        overflow;
  rd_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_id_q[$];

  int run_len = 0;
  int first_run_len = -1;
  int first_ov_cyc = -1;
  int fd_cnt = 0;
  bit seen70 = 0;
  bit hold_v = 0;
  logic [7:0]  hold_pix;
  logic [31:0] hold_id;

  mcu_raster_reorder #(.IMAGE_W(W), .IMAGE_H(H), .PIXEL_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ivalid    (ivalid),
    .ipixel    (ipixel),
`ifdef MCU_RASTER_REORDER_OREADY_EN
    .oready    (oready),
`endif
    .ovalid    (ovalid),
    .opixel    (opixel),
    .pixel_id  (pixel_id),
    .frame_done(frame_done),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // MCU-order stream: k-th pixel of a frame -> raster value (plus offset)
  function automatic logic [7:0] mcu_val(input int off, input int k);
    int s, rem, b, r, c, x, y;
    s   = k / SW;
    rem = k % SW;
    b   = rem / 64;
    r   = (rem % 64) / 8;
    c   = rem % 8;
    x   = b * 8 + c;
    y   = s * 8 + r;
    return 8'((y * W + x + off) % 256);
  endfunction

  // Model: the output is simply the frame in raster order with ids 0..FP-1
  task automatic push_frame_exp(input int off, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'((i + off) % 256));
      exp_id_q.push_back(32'(i));
    end
  endtask

  // Driver: one pixel, then gap-1 idle cycles; ivalid left high when gap=1
  task automatic feed(input int off, input int n, input int gap, output int t_done);
    t_done = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ivalid = 1'b1;
      ipixel = mcu_val(off, k % FP);
      if (k == SW - 1) t_done = cyc;
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
        ivalid = 1'b0;
      end
    end
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    ivalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    ivalid = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    exp_id_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ovalid", ovalid, 0);
    check("rst_opixel", opixel, 0);
    check("rst_pixel_id", pixel_id, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard / compare process
  always @(negedge clk) begin
    logic take;
    logic [7:0]  ep;
    logic [31:0] eid;
    if (!rst_n) begin
      run_len = 0;
      hold_v  = 0;
    end else begin
      if (ovalid) begin
        if (first_ov_cyc < 0) first_ov_cyc = cyc;
        run_len++;
      end else if (run_len > 0) begin
        if (first_run_len < 0) first_run_len = run_len;
        run_len = 0;
      end
`ifdef MCU_RASTER_REORDER_OREADY_EN
      if (hold_v) begin
        check("stall_ovalid", ovalid, 1);
        check("stall_opixel", opixel, hold_pix);
        check("stall_pixel_id", pixel_id, hold_id);
      end
      hold_v   = ovalid && !oready;
      hold_pix = opixel;
      hold_id  = pixel_id;
      take     = ovalid && oready;
`else
      take     = ovalid;
`endif
      if (take) begin
        if (exp_q.size() == 0) begin
          check("spurious_ovalid", 1, 0);
        end else begin
          ep  = exp_q.pop_front();
          eid = exp_id_q.pop_front();
          check("opixel", opixel, ep);
          check("pixel_id", pixel_id, eid);
          check("frame_done", frame_done, (eid == FP - 1));
          if (frame_done) fd_cnt++;
          if (eid == 70) seen70 = 1;
        end
      end
      if (!ovalid) check("frame_done_idle", frame_done, 0);
    end
  end

  initial begin
    int t_done, t_dummy, n;

    do_reset();

    // Pin the model with hand-computed values
    check("model_k8", mcu_val(0, 8), 16);
    check("model_k64", mcu_val(0, 64), 8);
    check("model_k127", mcu_val(0, 127), 127);
    check("model_k128", mcu_val(0, 128), 128);
    check("model_k200", mcu_val(0, 200), 152);

    // Frame with one pixel per 3 cycles: order, latency, stripe burst length
    first_run_len = -1;
    first_ov_cyc  = -1;
    fd_cnt        = 0;
    push_frame_exp(0, FP);
    feed(0, FP, 3, t_done);
    idle_in();
    wait_drain("drain_slow_frame");
    check("first_latency", first_ov_cyc - t_done, 2);
    check("first_run_len", first_run_len, SW);
    check("fd_cnt_slow", fd_cnt, 1);
    check("overflow_slow", overflow, 0);

    // Two back-to-back frames at full rate
    fd_cnt = 0;
    push_frame_exp(0, FP);
    push_frame_exp(77, FP);
    feed(0, FP, 1, t_dummy);
    feed(77, FP, 1, t_dummy);
    idle_in();
    wait_drain("drain_b2b");
    check("fd_cnt_b2b", fd_cnt, 2);
    check("overflow_b2b", overflow, 0);

    // Asynchronous reset mid-stream at pixel_id 70
    seen70 = 0;
    push_frame_exp(0, SW);
    feed(0, SW, 1, t_dummy);
    idle_in();
    n = 0;
    while (!seen70 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("seen_id70", seen70, 1);
    rst_n = 1'b0;
    #1;
    check("async_ovalid", ovalid, 0);
    check("async_opixel", opixel, 0);
    check("async_pixel_id", pixel_id, 0);
    check("async_frame_done", frame_done, 0);
    check("async_overflow", overflow, 0);
    exp_q.delete();
    exp_id_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fd_cnt = 0;
    push_frame_exp(33, FP);
    feed(33, FP, 1, t_dummy);
    idle_in();
    wait_drain("drain_after_reset");
    check("fd_cnt_after_reset", fd_cnt, 1);
    check("overflow_after_reset", overflow, 0);

`ifdef MCU_RASTER_REORDER_OREADY_EN
    // Stall the reader while three stripes arrive
    do_reset();
    oready = 1'b0;
    feed(0, 2 * SW, 1, t_dummy);
    @(posedge clk); #1;
    ipixel = mcu_val(0, 0);
    check("ovf_before_3rd", overflow, 0);
    @(posedge clk); #1;
    ivalid = 1'b0;
    check("ovf_at_3rd", overflow, 1);
    repeat (40) @(posedge clk);
    #1;
    check("ovf_sticky", overflow, 1);
    rst_n = 1'b0;
    #1;
    check("ovf_cleared", overflow, 0);
    check("ovf_rst_ovalid", ovalid, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    oready = 1'b1;

    // Random backpressure
    do_reset();
    push_frame_exp(5, FP);
    fork
      begin
        feed(5, FP, 3, t_dummy);
        idle_in();
      end
      begin
        int m = 0;
        while (exp_q.size() > 0 && m < 6000) begin
          @(posedge clk); #1;
          oready = 1'($urandom_range(0, 1));
          m++;
        end
      end
    join
    oready = 1'b1;
    check("rand_drain", exp_q.size(), 0);
    check("rand_overflow", overflow, 0);
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
